msg_sequencer: RTL

MSG_SEQUENCER -- requirements
Module: msg_sequencer

---
 rtl/msg_seq_pkg.sv | 25 ++
 rtl/msg_sequencer_tx_handshake.sv | 46 ++++
 rtl/msg_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/msg_seq_pkg.sv
// Shared definitions for the message sequencer: FSM state encoding and the
// supported memory-latency range.
package msg_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WAIT_MEM = 3'd2,
      ST_CHECK    = 3'd3,
      ST_START_TX = 3'd4,
      ST_TX       = 3'd5,
      ST_NEXT     = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 3;

   function automatic int clamp_mem_lat(input int lat);
      if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
      if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/msg_sequencer_tx_handshake.sv
// Transmitter handshake for the START_TX/TX states: request, launch detection
// and the abort that must wait for an in-flight byte to finish.
module tx_handshake (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_in_start,
   input  logic i_in_tx,
   input  logic i_busy,
   input  logic i_abort,
   output logic o_start,
   output logic o_to_tx,
   output logic o_to_next,
   output logic o_to_done
);

   logic pend_q;
   logic pend_d;
   logic abort_seen;

   assign abort_seen = pend_q | i_abort;

   // A byte counts as launched once busy is seen, so an abort arriving with
   // busy is deferred until the transmitter releases busy.
   always_comb begin
      pend_d = 1'b0;
      if (i_in_start) begin
         pend_d = i_busy & i_abort;
      end else if (i_in_tx) begin
         pend_d = abort_seen;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign o_start   = i_in_start;
   assign o_to_tx   = i_in_start & i_busy;
   assign o_to_done = (i_in_start & ~i_busy & i_abort) | (i_in_tx & ~i_busy & abort_seen);
   assign o_to_next = i_in_tx & ~i_busy & ~abort_seen;

endmodule

// File: rtl/msg_sequencer.sv
// Reads a message from memory byte by byte and hands each byte to a
// transmitter; length- or terminator-delimited, abortable at any point.
module msg_sequencer
   import msg_seq_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int TERM    = 0,
   parameter int MEM_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W:0]   i_len,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] i_byte,
   input  logic              i_busy,
   output logic [ADDR_W-1:0] o_address,
   output logic [DATA_W-1:0] o_data,
   output logic              o_start,
   output logic              o_active,
   output logic              o_done,
   output logic              o_aborted,
   output logic [ADDR_W:0]   o_count
);

   localparam int                LAT       = clamp_mem_lat(MEM_LAT);
   localparam logic [1:0]        WAIT_LAST = 2'(LAT - 1);
   localparam logic [DATA_W-1:0] TERM_V    = DATA_W'(TERM);
   localparam logic [ADDR_W:0]   FULL      = {1'b1, {ADDR_W{1'b0}}};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic                aborted_q, aborted_d;
   logic [1:0]          wait_q, wait_d;

   logic in_start_tx, in_tx, term_mode;
   logic hs_start, hs_to_tx, hs_to_next, hs_to_done;

   assign in_start_tx = (state_q == ST_START_TX);
   assign in_tx       = (state_q == ST_TX);
   assign term_mode   = (len_q == '0);

   tx_handshake u_tx_handshake (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_in_start (in_start_tx),
      .i_in_tx    (in_tx),
      .i_busy     (i_busy),
      .i_abort    (i_abort),
      .o_start    (hs_start),
      .o_to_tx    (hs_to_tx),
      .o_to_next  (hs_to_next),
      .o_to_done  (hs_to_done)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      count_d   = count_q;
      len_d     = len_q;
      aborted_d = aborted_q;
      wait_d    = wait_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_abort) begin
               addr_d    = i_base;
               len_d     = i_len;
               count_d   = '0;
               aborted_d = 1'b0;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (i_abort) begin
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               wait_d  = 2'd0;
               state_d = ST_WAIT_MEM;
            end
         end
         ST_WAIT_MEM: begin
            if (i_abort) begin
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_CHECK;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         ST_CHECK: begin
            data_d = i_byte;
            if (i_abort) begin
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end else if (term_mode ? (i_byte == TERM_V) : (count_q == len_q)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_START_TX;
            end
         end
         ST_START_TX: begin
            if (hs_to_tx) begin
               state_d = ST_TX;
            end else if (hs_to_done) begin
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_TX: begin
            if (hs_to_next) begin
               state_d = ST_NEXT;
            end else if (hs_to_done) begin
               // The byte in flight completed, so it is counted.
               count_d   = count_q + (ADDR_W+1)'(1);
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_NEXT: begin
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
            if (i_abort) begin
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end else if (term_mode && (count_d == FULL)) begin
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         count_q   <= '0;
         len_q     <= '0;
         aborted_q <= 1'b0;
         wait_q    <= 2'd0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         count_q   <= count_d;
         len_q     <= len_d;
         aborted_q <= aborted_d;
         wait_q    <= wait_d;
      end
   end

   assign o_address = addr_q;
   assign o_data    = data_q;
   assign o_count   = count_q;
   assign o_aborted = aborted_q;
   assign o_start   = hs_start;
   assign o_active  = (state_q != ST_IDLE);
   assign o_done    = (state_q == ST_DONE);

endmodule
